// File: rtl/voq_switch_pkg.sv
// voq_switch shared definitions: default parameters, derived widths
// and the per-ingress match record used by the scheduler.
package switch_pkg;

    localparam int DEF_N_PORTS      = 4;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_VOQ_DEPTH    = 8;
    localparam int DEF_EPOCH_CYCLES = 16;

    localparam int PORT_W = $clog2(DEF_N_PORTS);
    localparam int CNT_W  = $clog2(DEF_VOQ_DEPTH) + 1;

    // Widest port index the switch supports (16 ports).
    localparam int MAX_PORT_W = 4;

    typedef struct packed {
        logic                  valid;
        logic [MAX_PORT_W-1:0] dest;
    } match_t;

endpackage

// File: rtl/voq_switch_if.sv
// voq_switch cell bus: ingress injection with drop report and
// per-egress valid/ack holding registers.
interface voq_switch_if #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 32
);
    localparam int PW = $clog2(N_PORTS);

    logic                      in_valid;
    logic [PW-1:0]             in_port;
    logic [PW-1:0]             in_dest;
    logic [DATA_W-1:0]         in_data;
    logic                      in_drop;
    logic [N_PORTS-1:0]        out_valid;
    logic [N_PORTS*DATA_W-1:0] out_data;
    logic [N_PORTS-1:0]        out_ack;

    modport master (
        output in_valid, in_port, in_dest, in_data, out_ack,
        input  in_drop, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_port, in_dest, in_data, out_ack,
        output in_drop, out_valid, out_data
    );

endinterface

// File: rtl/voq_switch_voq_bank.sv
// One ingress worth of VOQs sharing a single cell memory.
// Reads are requested a cycle ahead of the pop so data is registered.
module voq_bank #(
    parameter int N_PORTS   = 4,
    parameter int DATA_W    = 32,
    parameter int VOQ_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(N_PORTS)-1:0] wr_dest,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic [$clog2(N_PORTS)-1:0] rd_dest,
    output logic [DATA_W-1:0]          rd_data,
    input  logic                       pop,
    input  logic [$clog2(N_PORTS)-1:0] pop_dest,
    output logic [N_PORTS-1:0]         empty,
    output logic [N_PORTS-1:0]         full
);
    localparam int PW = $clog2(N_PORTS);
    localparam int DW = $clog2(VOQ_DEPTH);
    localparam int CW = DW + 1;

    logic [DATA_W-1:0] mem [N_PORTS*VOQ_DEPTH];
    logic [DW-1:0]     head [N_PORTS];
    logic [DW-1:0]     tail [N_PORTS];
    logic [CW-1:0]     cnt  [N_PORTS];
    logic [N_PORTS-1:0] push_v;
    logic [N_PORTS-1:0] pop_v;

    // Fullness and emptiness come from the count at the start of the cycle.
    always_comb begin
        for (int d = 0; d < N_PORTS; d++) begin
            empty[d]  = (cnt[d] == '0);
            full[d]   = (cnt[d] == CW'(VOQ_DEPTH));
            push_v[d] = wr_en && (wr_dest == PW'(d)) && !full[d];
            pop_v[d]  = pop && (pop_dest == PW'(d)) && !empty[d];
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < N_PORTS; d++) begin
                head[d] <= '0;
                tail[d] <= '0;
                cnt[d]  <= '0;
            end
        end else begin
            for (int d = 0; d < N_PORTS; d++) begin
                head[d] <= head[d] + DW'(pop_v[d]);
                tail[d] <= tail[d] + DW'(push_v[d]);
                cnt[d]  <= cnt[d] + CW'(push_v[d]) - CW'(pop_v[d]);
            end
        end
    end

    // Cell storage, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en && !full[wr_dest])
            mem[{wr_dest, tail[wr_dest]}] <= wr_data;
    end

    // Registered head-of-queue read for the matched destination.
    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[{rd_dest, head[rd_dest]}];
    end

endmodule

// File: rtl/voq_switch.sv
// N-port input-queued cell switch: VOQ banks, epoch round-robin
// scheduler, crossbar and egress holding registers. VOQ_SWITCH_STATS_EN adds counters.
module voq_switch
    import switch_pkg::*;
#(
    parameter int N_PORTS      = DEF_N_PORTS,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int VOQ_DEPTH    = DEF_VOQ_DEPTH,
    parameter int EPOCH_CYCLES = DEF_EPOCH_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    voq_switch_if.slave                  bus,
    output logic [N_PORTS*N_PORTS-1:0]   voq_empty,
    input  logic [$clog2(N_PORTS)-1:0]   stat_sel,
    output logic [31:0]                  stat_tx,
    output logic [31:0]                  stat_drop
);
    localparam int PW = $clog2(N_PORTS);
    localparam int EW = $clog2(EPOCH_CYCLES);

    logic [EW-1:0]      ecnt;
    logic [PW-1:0]      gptr;
    logic [PW-1:0]      iptr [N_PORTS];
    match_t             match_d [N_PORTS];
    match_t             match_q [N_PORTS];
    logic [N_PORTS-1:0] bank_empty [N_PORTS];
    logic [N_PORTS-1:0] bank_full [N_PORTS];
    logic [DATA_W-1:0]  rd_data [N_PORTS];
    logic [N_PORTS-1:0] claimed;
    logic [PW-1:0]      ing;
    logic [PW-1:0]      egr;
    logic               sched;
    logic               drop_now;

    assign sched    = (ecnt == '0) && enable;
    assign drop_now = bus.in_valid && bank_full[bus.in_port][bus.in_dest];

    for (genvar i = 0; i < N_PORTS; i++) begin : g_bank
        voq_bank #(
            .N_PORTS  (N_PORTS),
            .DATA_W   (DATA_W),
            .VOQ_DEPTH(VOQ_DEPTH)
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (bus.in_valid && (bus.in_port == PW'(i))),
            .wr_dest (bus.in_dest),
            .wr_data (bus.in_data),
            .rd_en   (match_d[i].valid),
            .rd_dest (match_d[i].dest[PW-1:0]),
            .rd_data (rd_data[i]),
            .pop     (match_q[i].valid),
            .pop_dest(match_q[i].dest[PW-1:0]),
            .empty   (bank_empty[i]),
            .full    (bank_full[i])
        );
        for (genvar j = 0; j < N_PORTS; j++) begin : g_emp
            assign voq_empty[i*N_PORTS+j] = bank_empty[i][j];
        end
    end

    // Epoch match: ingresses from gptr, each searching egresses from its iptr.
    always_comb begin
        claimed = '0;
        ing     = '0;
        egr     = '0;
        for (int i = 0; i < N_PORTS; i++)
            match_d[i] = '0;
        if (sched) begin
            for (int k = 0; k < N_PORTS; k++) begin
                ing = gptr + PW'(k);
                for (int m = 0; m < N_PORTS; m++) begin
                    egr = iptr[ing] + PW'(m);
                    if (!match_d[ing].valid && !bank_empty[ing][egr] &&
                        !claimed[egr] && !bus.out_valid[egr]) begin
                        match_d[ing].valid = 1'b1;
                        match_d[ing].dest  = MAX_PORT_W'(egr);
                        claimed[egr]       = 1'b1;
                    end
                end
            end
        end
    end

    // Epoch counter, match register and fairness pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ecnt <= '0;
            gptr <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                iptr[i]    <= '0;
                match_q[i] <= '0;
            end
        end else begin
            ecnt <= (ecnt == EW'(EPOCH_CYCLES - 1)) ? '0 : ecnt + EW'(1);
            for (int i = 0; i < N_PORTS; i++)
                match_q[i] <= match_d[i];
            if (sched) begin
                gptr <= gptr + PW'(1);
                for (int i = 0; i < N_PORTS; i++)
                    if (match_d[i].valid)
                        iptr[i] <= match_d[i].dest[PW-1:0] + PW'(1);
            end
        end
    end

    // Crossbar into egress holding registers; ack frees the register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= '0;
            bus.out_data  <= '0;
        end else begin
            for (int j = 0; j < N_PORTS; j++) begin
                if (bus.out_ack[j])
                    bus.out_valid[j] <= 1'b0;
                for (int i = 0; i < N_PORTS; i++) begin
                    if (match_q[i].valid && match_q[i].dest[PW-1:0] == PW'(j)) begin
                        bus.out_valid[j]                 <= 1'b1;
                        bus.out_data[j*DATA_W +: DATA_W] <= rd_data[i];
                    end
                end
            end
        end
    end

    // Drop pulse for a cell refused in the previous cycle.
    always_ff @(posedge clk) begin
        if (reset)
            bus.in_drop <= 1'b0;
        else
            bus.in_drop <= drop_now;
    end

`ifdef VOQ_SWITCH_STATS_EN
    logic [31:0] tx_cnt   [N_PORTS];
    logic [31:0] drop_cnt [N_PORTS];

    // Delivered and dropped cell counters, wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < N_PORTS; j++) begin
                tx_cnt[j]   <= '0;
                drop_cnt[j] <= '0;
            end
        end else begin
            for (int j = 0; j < N_PORTS; j++)
                if (bus.out_valid[j] && bus.out_ack[j])
                    tx_cnt[j] <= tx_cnt[j] + 32'd1;
            if (drop_now)
                drop_cnt[bus.in_port] <= drop_cnt[bus.in_port] + 32'd1;
        end
    end

    assign stat_tx   = tx_cnt[stat_sel];
    assign stat_drop = drop_cnt[stat_sel];
`else
    logic stat_unused;
    assign stat_unused = ^stat_sel;
    assign stat_tx     = '0;
    assign stat_drop   = '0;
`endif

endmodule

// File: tb/tb_voq_switch.sv
// Self-checking bench for voq_switch (4 ports, depth 8, 16-cycle epochs).
// Egress data is scored against per-egress expected queues.
module tb_voq_switch;
    import switch_pkg::*;

    localparam int N  = DEF_N_PORTS;
    localparam int DW = DEF_DATA_W;
    localparam int EP = DEF_EPOCH_CYCLES;
`ifdef VOQ_SWITCH_STATS_EN
    localparam logic [63:0] ST = 64'd1;
`else
    localparam logic [63:0] ST = 64'd0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [PORT_W-1:0] stat_sel = '0;
    logic [N*N-1:0]    voq_empty;
    logic [31:0]       stat_tx;
    logic [31:0]       stat_drop;

    voq_switch_if #(.N_PORTS(N), .DATA_W(DW)) bus ();

    voq_switch #(
        .N_PORTS     (N),
        .DATA_W      (DW),
        .VOQ_DEPTH   (DEF_VOQ_DEPTH),
        .EPOCH_CYCLES(EP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .bus      (bus),
        .voq_empty(voq_empty),
        .stat_sel (stat_sel),
        .stat_tx  (stat_tx),
        .stat_drop(stat_drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int deliv = 0;
    int tb_ecnt = 0;
    logic [CNT_W+27:0] exp_q [N][$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        enable       = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ack  = '1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic send(int p, int d, logic [31:0] data, bit ok);
        bus.in_valid = 1'b1;
        bus.in_port  = 2'(p);
        bus.in_dest  = 2'(d);
        bus.in_data  = data;
        tick(1);
        bus.in_valid = 1'b0;
        if (ok) exp_q[d].push_back(data);
    endtask

    task automatic wait_epoch();
        int k = 0;
        while (tb_ecnt != 0 && k < 64) begin
            tick(1);
            k++;
        end
        if (k >= 64) check("epoch_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain_check(string tag);
        for (int j = 0; j < N; j++)
            check(tag, 64'(exp_q[j].size()), 64'd0);
    endtask

    // Epoch position of the current cycle.
    initial forever begin
        @(posedge clk);
        if (reset) tb_ecnt = 0;
        else tb_ecnt = (tb_ecnt == EP - 1) ? 0 : tb_ecnt + 1;
    end

    // Egress scoreboard: every valid&ack handshake must match the queue head.
    initial forever begin
        @(negedge clk);
        for (int j = 0; j < N; j++) begin
            if (!reset && bus.out_valid[j] && bus.out_ack[j]) begin
                deliv++;
                if (exp_q[j].size() == 0)
                    check("unexpected_cell", 64'd1, 64'd0);
                else
                    check("cell_data", 64'(bus.out_data[j*DW +: DW]),
                          64'(exp_q[j].pop_front()));
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_port  = '0;
        bus.in_dest  = '0;
        bus.in_data  = '0;
        bus.out_ack  = '1;
        do_reset();
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data", 64'(|bus.out_data), 64'd0);
        check("rst_empty", 64'(voq_empty), 64'hFFFF);
        check("rst_drop", 64'(bus.in_drop), 64'd0);

        // single cell 0->2, timing and ack
        bus.out_ack = 4'b1011;
        send(0, 2, 32'hA5A5, 1'b1);
        check("t1_enq", 64'(voq_empty[2]), 64'd0);
        wait_epoch();
        enable = 1'b1;
        tick(1);
        check("t1_e1", 64'(bus.out_valid), 64'd0);
        tick(1);
        check("t1_valid", 64'(bus.out_valid), 64'h4);
        check("t1_data", 64'(bus.out_data[64 +: 32]), 64'hA5A5);
        check("t1_pop", 64'(voq_empty), 64'hFFFF);
        tick(4);
        check("t1_hold", 64'(bus.out_data[64 +: 32]), 64'hA5A5);
        check("t1_hold_v", 64'(bus.out_valid), 64'h4);
        bus.out_ack = '1;
        stat_sel = 2'd2;
        tick(1);
        check("t1_ack", 64'(bus.out_valid), 64'd0);
        check("t1_tx", 64'(stat_tx), ST);
        drain_check("t1_drain");

        // overflow one VOQ, FIFO order out
        do_reset();
        for (int k = 0; k < 9; k++) begin
            send(1, 3, 32'h100 + 32'(k), k < 8);
            if (k == 7) check("t2_nodrop", 64'(bus.in_drop), 64'd0);
        end
        stat_sel = 2'd1;
        check("t2_drop", 64'(bus.in_drop), 64'd1);
        check("t2_stat", 64'(stat_drop), ST);
        check("t2_enq", 64'(voq_empty[7]), 64'd0);
        tick(1);
        check("t2_pulse", 64'(bus.in_drop), 64'd0);
        deliv = 0;
        wait_epoch();
        enable = 1'b1;
        tick(8 * EP + 4);
        check("t2_count", 64'(deliv), 64'd8);
        check("t2_empty", 64'(voq_empty), 64'hFFFF);
        drain_check("t2_drain");

        // all ingresses to egress 0: order 0,1,2,3
        do_reset();
        for (int i = 0; i < N; i++)
            send(i, 0, 32'h300 + 32'(i), 1'b1);
        deliv = 0;
        wait_epoch();
        enable = 1'b1;
        tick(EP);
        check("t3_one", 64'(deliv), 64'd1);
        tick(3 * EP + 4);
        check("t3_count", 64'(deliv), 64'd4);
        drain_check("t3_drain");

        // busy egress 1 is not reissued until acked
        do_reset();
        bus.out_ack = 4'b1101;
        send(2, 1, 32'h401, 1'b1);
        send(2, 1, 32'h402, 1'b1);
        wait_epoch();
        enable = 1'b1;
        tick(2);
        check("t4_valid", 64'(bus.out_valid[1]), 64'd1);
        check("t4_data", 64'(bus.out_data[32 +: 32]), 64'h401);
        tick(EP);
        check("t4_busy", 64'(bus.out_data[32 +: 32]), 64'h401);
        check("t4_queued", 64'(voq_empty[9]), 64'd0);
        bus.out_ack = '1;
        tick(1);
        bus.out_ack = 4'b1101;
        check("t4_clr", 64'(bus.out_valid[1]), 64'd0);
        wait_epoch();
        tick(1);
        check("t4_e1", 64'(bus.out_valid[1]), 64'd0);
        tick(1);
        check("t4_next", 64'(bus.out_valid[1]), 64'd1);
        check("t4_data2", 64'(bus.out_data[32 +: 32]), 64'h402);
        bus.out_ack = '1;
        tick(2);
        drain_check("t4_drain");

        // permutation: all egresses in one cycle
        do_reset();
        for (int i = 0; i < N; i++)
            send(i, (i + 1) % N, 32'h500 + 32'(i), 1'b1);
        wait_epoch();
        enable = 1'b1;
        tick(2);
        check("t5_all", 64'(bus.out_valid), 64'hF);
        tick(2);
        drain_check("t5_drain");

        // reset in the middle of a dequeue
        do_reset();
        send(0, 1, 32'h601, 1'b1);
        send(3, 2, 32'h602, 1'b1);
        wait_epoch();
        enable = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(1);
        check("t6_valid", 64'(bus.out_valid), 64'd0);
        check("t6_data", 64'(|bus.out_data), 64'd0);
        check("t6_drop", 64'(bus.in_drop), 64'd0);
        check("t6_empty", 64'(voq_empty), 64'hFFFF);
        check("t6_tx", 64'(stat_tx), 64'd0);
        check("t6_sdrop", 64'(stat_drop), 64'd0);
        for (int j = 0; j < N; j++) exp_q[j].delete();
        reset = 1'b0;
        tick(3);
        check("t6_quiet", 64'(bus.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/voq_switch.md
# voq_switch

Parametrised N-port, input-queued, cell-based switch core; the successor to the fixed 4-port simple switch. It integrates per-ingress virtual output queues (VOQs), an epoch-driven round-robin scheduler, a crossbar and egress holding registers with ack handshake. It sits between the host register interface (cell injection, cell readback) and the rest of the fabric, and adds per-port fairness pointers, busy-egress exclusion and drop reporting.

## Interface
- `N_PORTS`, 4: ingress and egress port count (power of 2, 2..16).
- `DATA_W`, 32: cell width in bits.
- `VOQ_DEPTH`, 8: cells per VOQ (power of 2).
- `EPOCH_CYCLES`, 16: cycles per scheduling epoch (≥4).
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: experiment running; scheduling only while high.
- `in_valid` in 1: enqueue strobe.
- `in_port` in log2(N_PORTS): ingress port index.
- `in_dest` in log2(N_PORTS): destination egress.
- `in_data` in DATA_W: cell payload.
- `in_drop` out 1: pulse, the cell in the previous cycle was dropped (VOQ full).
- `voq_empty` out N_PORTS*N_PORTS: bit i*N_PORTS+j means VOQ(i→j) is empty.
- `out_valid` out N_PORTS: egress j holds a cell.
- `out_data` out N_PORTS*DATA_W: egress j data in slice j.
- `out_ack` in N_PORTS: consumer accepts egress j.
- `stat_sel` in log2(N_PORTS): statistics port select.
- `stat_tx` out 32: cells delivered by egress stat_sel.
- `stat_drop` out 32: cells dropped at ingress stat_sel.

## Operation
- Enqueue: on `in_valid`, the cell is written to VOQ(in_port→in_dest) if its count < VOQ_DEPTH, else dropped and `in_drop` pulses next cycle. Fullness is judged on the count at the start of the cycle; a same-cycle dequeue does not free a slot for the incoming cell.
- Epoch counter `ecnt` runs 0..EPOCH_CYCLES-1, wraps, and free-runs regardless of `enable`.
- Match (at `ecnt==0` with `enable`=1): ingress ports are visited in order starting at global pointer `gptr`. Each ingress i picks the first egress j, searched from its own pointer `iptr[i]`, that is non-empty in VOQ(i→j), not yet claimed this epoch, and not busy (`out_valid[j]` high at this cycle). At most one cell per ingress and one per egress.
- Pointer update when the match is registered: `iptr[i]` ← j+1 mod N_PORTS for each matched i; `gptr` ← gptr+1 mod N_PORTS every scheduled epoch, matched or not.
- Dequeue: matched VOQs pop one cell each. The crossbar routes it into egress register j, sets `out_valid[j]`, and holds `out_data` stable until `out_ack[j]`.
- `out_ack[j]` with `out_valid[j]` clears valid next cycle. An ack without valid is ignored.
- `enable` falling mid-epoch: any in-flight match completes. No new match is made.
- Reset: all VOQs empty, `ecnt`=0, `gptr`=0, `iptr`=0, `out_valid`=0, `out_data`=0, `in_drop`=0, `voq_empty` all ones, stats 0.

## Timing
- Cycle E (`ecnt==0`): match is computed combinationally and registered.
- E+1: VOQ read and pop.
- E+2: `out_valid` high with data. Latency from match to valid is 2 cycles.
- Enqueue latency: `voq_empty` bit clears 1 cycle after `in_valid`. A cell enqueued at cycle E is not eligible until the next epoch.
- A pop at E+1 updates `voq_empty` at E+2.
- Throughput: at most N_PORTS cells per epoch.

## Configuration
- `VOQ_SWITCH_STATS_EN` defined: 32-bit wrapping counters. `stat_tx[j]` increments on each `out_valid&out_ack` handshake; `stat_drop[i]` increments on each drop. Outputs are muxed combinationally by `stat_sel`.
- Undefined: no counters; `stat_tx` and `stat_drop` are tied to 0.

## Structure
- Package `switch_pkg`: default parameters, `PORT_W` = $clog2(N_PORTS), `CNT_W` = $clog2(VOQ_DEPTH)+1, and a typedef for per-ingress match records {valid, dest}.
- Sub-module `voq_bank`: one per ingress, N_PORTS VOQs sharing one memory. Interface is write (dest, data), pop (dest), empty vector and full vector, with registered read data.
- Scheduler, crossbar and egress registers are in the top level.

## Test plan
- N=4, one cell 0→2 data 0xA5A5, enable: `out_valid[2]` rises at E+2 with 0xA5A5; ack returns valid to 0 and `stat_tx[2]`=1.
- 9 cells into VOQ(1→3) with depth 8: the 9th pulses `in_drop`, `stat_drop[1]`=1, and exactly 8 cells emerge over 8 epochs in FIFO order.
- Ingresses 0..3 all target egress 0: deliveries rotate, starting with ingress 0 and followed by 1, 2, 3 (`gptr` fairness), one cell per epoch.
- Egress 1 never acked with a cell queued 2→1: no new cell is issued to egress 1. Once acked, the next cell appears at E+2 of the following epoch.
- Permutation 0→1, 1→2, 2→3, 3→0 at one epoch: all four `out_valid` bits rise in the same cycle.
- `reset` asserted at E+1: next cycle all outputs are at reset values and `voq_empty` is all ones.
